// File: rtl/axilite_write_arbiter.sv
// Two-requester AXI4-Lite write-channel arbiter: round-robin grant held for a
// whole AW/W/B transaction, with combinational pass-through while granted.
module axilite_write_arbiter #(
    parameter int AXILITE_ADDR_WIDTH = 48,
    parameter int AXILITE_DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [AXILITE_ADDR_WIDTH-1:0] s0_awaddr,
    input  logic                          s0_awvalid,
    output logic                          s0_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s0_wdata,
    input  logic                          s0_wvalid,
    output logic                          s0_wready,
    output logic [1:0]                    s0_bresp,
    output logic                          s0_bvalid,
    input  logic                          s0_bready,

    input  logic [AXILITE_ADDR_WIDTH-1:0] s1_awaddr,
    input  logic                          s1_awvalid,
    output logic                          s1_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s1_wdata,
    input  logic                          s1_wvalid,
    output logic                          s1_wready,
    output logic [1:0]                    s1_bresp,
    output logic                          s1_bvalid,
    input  logic                          s1_bready,

    output logic [AXILITE_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXILITE_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,

    output logic                          grant_id,
    output logic                          busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_WAIT_B = 2'd2;

    logic [1:0] state;
    logic       aw_done;
    logic       w_done;
    logic       rr_last;

    logic       req0;
    logic       req1;
    logic       arb_grant;
    logic       in_xfer;
    logic       in_wait;

    logic [AXILITE_ADDR_WIDTH-1:0] sel_awaddr;
    logic [AXILITE_DATA_WIDTH-1:0] sel_wdata;
    logic       sel_awvalid;
    logic       sel_wvalid;
    logic       sel_bready;

    logic       g_awready;
    logic       g_wready;
    logic       g_bvalid;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;

    assign req0 = s0_awvalid | s0_wvalid;
    assign req1 = s1_awvalid | s1_wvalid;

    // On a tie the requester that was not served last wins.
    assign arb_grant = (req0 & req1) ? ~rr_last : req1;

    assign in_xfer = (state == ST_XFER);
    assign in_wait = (state == ST_WAIT_B);
    assign busy    = (state != ST_IDLE);

    assign sel_awaddr  = grant_id ? s1_awaddr  : s0_awaddr;
    assign sel_wdata   = grant_id ? s1_wdata   : s0_wdata;
    assign sel_awvalid = grant_id ? s1_awvalid : s0_awvalid;
    assign sel_wvalid  = grant_id ? s1_wvalid  : s0_wvalid;
    assign sel_bready  = grant_id ? s1_bready  : s0_bready;

    assign m_axi_awaddr  = busy ? sel_awaddr : '0;
    assign m_axi_wdata   = busy ? sel_wdata  : '0;
    assign m_axi_awvalid = in_xfer & sel_awvalid & ~aw_done;
    assign m_axi_wvalid  = in_xfer & sel_wvalid  & ~w_done;
    assign m_axi_bready  = in_wait & sel_bready;

    // A B beat arriving outside WAIT_B is held off by bready staying low.
    assign g_awready = in_xfer & m_axi_awready & ~aw_done;
    assign g_wready  = in_xfer & m_axi_wready  & ~w_done;
    assign g_bvalid  = in_wait & m_axi_bvalid;

    assign s0_awready = g_awready & ~grant_id;
    assign s0_wready  = g_wready  & ~grant_id;
    assign s0_bvalid  = g_bvalid  & ~grant_id;
    assign s0_bresp   = (in_wait & ~grant_id) ? m_axi_bresp : 2'b00;

    assign s1_awready = g_awready & grant_id;
    assign s1_wready  = g_wready  & grant_id;
    assign s1_bvalid  = g_bvalid  & grant_id;
    assign s1_bresp   = (in_wait & grant_id) ? m_axi_bresp : 2'b00;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;

    // rr_last resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rr_last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        grant_id <= arb_grant;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (b_hs) begin
                        rr_last <= grant_id;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_write_arbiter.sv
// Scenario bench for axilite_write_arbiter: inputs change 1ns after the rising
// edge, outputs are checked on the falling edge.
module tb_axilite_write_arbiter;

    localparam int AW = 48;
    localparam int DW = 64;

    logic clk;
    logic rst_n;

    logic [1:0][AW-1:0] s_awaddr;
    logic [1:0][DW-1:0] s_wdata;
    logic [1:0]         s_awvalid;
    logic [1:0]         s_wvalid;
    logic [1:0]         s_bready;

    logic          s0_awready, s0_wready, s0_bvalid;
    logic          s1_awready, s1_wready, s1_bvalid;
    logic [1:0]    s0_bresp, s1_bresp;

    logic [AW-1:0] m_awaddr;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic          m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic          grant_id, busy;

    int total;
    int bad;

    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] exp_addr0_q[$];
    logic [AW-1:0] exp_addr1_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [1:0]    exp_resp_q[$];
    logic          exp_gid_q[$];

    axilite_write_arbiter #(
        .AXILITE_ADDR_WIDTH(AW),
        .AXILITE_DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s0_awaddr    (s_awaddr[0]),
        .s0_awvalid   (s_awvalid[0]),
        .s0_awready   (s0_awready),
        .s0_wdata     (s_wdata[0]),
        .s0_wvalid    (s_wvalid[0]),
        .s0_wready    (s0_wready),
        .s0_bresp     (s0_bresp),
        .s0_bvalid    (s0_bvalid),
        .s0_bready    (s_bready[0]),
        .s1_awaddr    (s_awaddr[1]),
        .s1_awvalid   (s_awvalid[1]),
        .s1_awready   (s1_awready),
        .s1_wdata     (s_wdata[1]),
        .s1_wvalid    (s_wvalid[1]),
        .s1_wready    (s1_wready),
        .s1_bresp     (s1_bresp),
        .s1_bvalid    (s1_bvalid),
        .s1_bready    (s_bready[1]),
        .m_axi_awaddr (m_awaddr),
        .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .m_axi_wdata  (m_wdata),
        .m_axi_wvalid (m_wvalid),
        .m_axi_wready (m_wready),
        .m_axi_bresp  (m_bresp),
        .m_axi_bvalid (m_bvalid),
        .m_axi_bready (m_bready),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s_awaddr  = '0;
        s_wdata   = '0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sample();
        total++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state busy=%b grant=%b required 0/0", busy, grant_id);
        end
        total++;
        if ({m_awvalid, m_wvalid, m_bready, s0_awready, s0_wready, s0_bvalid,
             s1_awready, s1_wready, s1_bvalid} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_handshakes awv=%b wv=%b bready=%b required all 0",
                     m_awvalid, m_wvalid, m_bready);
        end
    endtask

    task automatic test_single();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0]    er;
        tick();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s_awaddr[0] = 48'h2000_0000;
        s_wdata[0]  = 64'h1;
        s_awvalid[0] = 1'b1;
        s_wvalid[0]  = 1'b1;
        s_bready[0]  = 1'b1;
        exp_addr_q.push_back(48'h2000_0000);
        exp_data_q.push_back(64'h1);
        exp_resp_q.push_back(2'b00);
        sample();
        total++;
        if (m_awvalid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_request_cycle awvalid=%b busy=%b required 0/0", m_awvalid, busy);
        end
        tick();
        sample();
        total++;
        if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_forward awv=%b wv=%b grant=%b required 1/1/0",
                     m_awvalid, m_wvalid, grant_id);
        end
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        total++;
        if (m_awaddr !== ea || m_wdata !== ed) begin
            bad++;
            $display("[TB] FAIL single_payload addr=%h data=%h required %h/%h", m_awaddr, m_wdata, ea, ed);
        end
        tick();
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        sample();
        er = exp_resp_q.pop_front();
        total++;
        if (s0_bvalid !== 1'b1 || s0_bresp !== er || m_bready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_bresp bvalid=%b bresp=%b bready=%b required 1/%b/1",
                     s0_bvalid, s0_bresp, m_bready, er);
        end
        tick();
        m_bvalid = 1'b0;
        s_bready[0] = 1'b0;
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_busy_drop busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] hs_aw, hs_w, hs_b, inflight;
        int issued[2];
        bit slv_aw, slv_w, m_hs_b;
        int served, viol;
        logic eg;
        logic [AW-1:0] ea;
        do_reset();
        exp_gid_q = {1'b0, 1'b1, 1'b0, 1'b1};
        m_awready = 1'b1;
        m_wready  = 1'b1;
        hs_aw = '0; hs_w = '0; hs_b = '0; inflight = '0;
        issued[0] = 0; issued[1] = 0;
        slv_aw = 0; slv_w = 0; m_hs_b = 0;
        served = 0; viol = 0;
        for (int cyc = 0; cyc < 200 && served < 4; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (hs_aw[i]) s_awvalid[i] = 1'b0;
                if (hs_w[i])  s_wvalid[i]  = 1'b0;
                if (hs_b[i])  inflight[i]  = 1'b0;
                if (!inflight[i] && issued[i] < 2) begin
                    s_awaddr[i] = (i == 0 ? 48'h2000_0000 : 48'h3000_0000) + 48'(issued[i] * 8);
                    s_wdata[i]  = 64'(i * 256 + issued[i]);
                    s_awvalid[i] = 1'b1;
                    s_wvalid[i]  = 1'b1;
                    s_bready[i]  = 1'b1;
                    inflight[i]  = 1'b1;
                    issued[i]++;
                    if (i == 0) exp_addr0_q.push_back(s_awaddr[i]);
                    else        exp_addr1_q.push_back(s_awaddr[i]);
                end
            end
            if (m_hs_b) begin
                m_bvalid = 1'b0;
                slv_aw = 0;
                slv_w  = 0;
            end else if (slv_aw && slv_w) begin
                m_bvalid = 1'b1;
            end
            sample();
            hs_aw  = s_awvalid & {s1_awready, s0_awready};
            hs_w   = s_wvalid  & {s1_wready,  s0_wready};
            hs_b   = s_bready  & {s1_bvalid,  s0_bvalid};
            m_hs_b = m_bvalid & m_bready;
            if (m_awvalid && m_awready) begin
                slv_aw = 1;
                if (exp_gid_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rr_extra_aw addr=%h required no further AW", m_awaddr);
                end else begin
                    eg = exp_gid_q.pop_front();
                    total++;
                    if (grant_id !== eg) begin
                        bad++;
                        $display("[TB] FAIL rr_grant_order grant=%b required %b", grant_id, eg);
                    end
                    if (eg) ea = (exp_addr1_q.size() > 0) ? exp_addr1_q.pop_front() : '1;
                    else    ea = (exp_addr0_q.size() > 0) ? exp_addr0_q.pop_front() : '1;
                    total++;
                    if (m_awaddr !== ea) begin
                        bad++;
                        $display("[TB] FAIL rr_awaddr addr=%h required %h", m_awaddr, ea);
                    end
                end
            end
            if (m_wvalid && m_wready) slv_w = 1;
            if (m_hs_b) served++;
            if (busy && grant_id == 1'b0 && (s1_awready || s1_wready || s1_bvalid)) viol++;
            if (busy && grant_id == 1'b1 && (s0_awready || s0_wready || s0_bvalid)) viol++;
            if (served < 4) tick();
        end
        total++;
        if (served != 4) begin
            bad++;
            $display("[TB] FAIL rr_completed served=%0d required 4", served);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("[TB] FAIL rr_isolation leaks=%0d required 0", viol);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_split();
        int aw_beats;
        tick();
        s_awaddr[0] = 48'h2000_0100;
        s_wdata[0]  = 64'hA5;
        s_awvalid[0] = 1'b1;
        s_wvalid[0]  = 1'b1;
        s_bready[0]  = 1'b1;
        m_awready = 1'b1;
        m_wready  = 1'b0;
        m_bvalid  = 1'b1;
        aw_beats = 0;
        sample();
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) m_wready = 1'b1;
            if (c == 6) begin
                s_awvalid[0] = 1'b0;
                s_wvalid[0]  = 1'b0;
            end
            sample();
            if (m_awvalid && m_awready) aw_beats++;
            total++;
            if (m_awvalid !== (c == 1) || m_wvalid !== (c <= 5)) begin
                bad++;
                $display("[TB] FAIL split_valids c=%0d awv=%b wv=%b required %b/%b",
                         c, m_awvalid, m_wvalid, (c == 1), (c <= 5));
            end
            total++;
            if (m_bready !== (c == 6)) begin
                bad++;
                $display("[TB] FAIL split_wait_b c=%0d bready=%b required %b", c, m_bready, (c == 6));
            end
        end
        total++;
        if (aw_beats != 1) begin
            bad++;
            $display("[TB] FAIL split_aw_beats beats=%0d required 1", aw_beats);
        end
        tick();
        clear_inputs();
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL split_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] er;
        tick();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s_awaddr[0] = 48'h2000_0200;
        s_wdata[0]  = 64'h2;
        s_awvalid[0] = 1'b1;
        s_wvalid[0]  = 1'b1;
        s_bready[0]  = 1'b0;
        exp_resp_q.push_back(2'b10);
        tick();
        tick();
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        m_bvalid = 1'b1;
        m_bresp  = 2'b10;
        for (int c = 0; c < 3; c++) begin
            sample();
            total++;
            if (m_bready !== 1'b0 || busy !== 1'b1 || s0_bvalid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL bp_hold c=%0d bready=%b busy=%b bvalid=%b required 0/1/1",
                         c, m_bready, busy, s0_bvalid);
            end
            tick();
        end
        s_bready[0] = 1'b1;
        sample();
        er = exp_resp_q.pop_front();
        total++;
        if (m_bready !== 1'b1 || s0_bvalid !== 1'b1 || s0_bresp !== er) begin
            bad++;
            $display("[TB] FAIL bp_release bready=%b bvalid=%b bresp=%b required 1/1/%b",
                     m_bready, s0_bvalid, s0_bresp, er);
        end
        tick();
        clear_inputs();
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] ea;
        tick();
        s_awaddr[1] = 48'h3000_0300;
        s_wdata[1]  = 64'h3;
        s_awvalid[1] = 1'b1;
        s_wvalid[1]  = 1'b1;
        s_bready[1]  = 1'b1;
        m_awready = 1'b1;
        m_wready  = 1'b0;
        tick();
        sample();
        total++;
        if (grant_id !== 1'b1 || m_awvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rm_grant grant=%b awv=%b required 1/1", grant_id, m_awvalid);
        end
        tick();
        s_awvalid[1] = 1'b0;
        rst_n = 1'b0;
        sample();
        total++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rm_aw_only awv=%b wv=%b required 0/1", m_awvalid, m_wvalid);
        end
        tick();
        rst_n = 1'b1;
        s_wvalid[1] = 1'b0;
        sample();
        total++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rm_state busy=%b grant=%b required 0/0", busy, grant_id);
        end
        total++;
        if ({m_awvalid, m_wvalid, m_bready, s1_awready, s1_wready, s1_bvalid} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rm_outputs awv=%b wv=%b bready=%b s1aw=%b s1w=%b required all 0",
                     m_awvalid, m_wvalid, m_bready, s1_awready, s1_wready);
        end
        tick();
        m_wready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = (i == 0 ? 48'h2000_0400 : 48'h3000_0400);
            s_wdata[i]  = 64'(16 + i);
            s_awvalid[i] = 1'b1;
            s_wvalid[i]  = 1'b1;
        end
        exp_addr_q.push_back(48'h2000_0400);
        tick();
        sample();
        ea = exp_addr_q.pop_front();
        total++;
        if (grant_id !== 1'b0 || m_awvalid !== 1'b1 || m_awaddr !== ea || s1_awready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rm_fresh grant=%b awv=%b addr=%h s1aw=%b required 0/1/%h/0",
                     grant_id, m_awvalid, m_awaddr, s1_awready, ea);
        end
        do_reset();
    endtask

    task automatic test_early_b();
        tick();
        m_bvalid = 1'b1;
        m_bresp  = 2'b01;
        s_bready[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                s_awaddr[0] = 48'h2000_0500;
                s_wdata[0]  = 64'h5;
                s_awvalid[0] = 1'b1;
                s_wvalid[0]  = 1'b1;
            end
            if (c == 3) begin
                m_awready = 1'b1;
                m_wready  = 1'b1;
            end
            sample();
            total++;
            if (m_bready !== 1'b0 || s0_bvalid !== 1'b0 || s1_bvalid !== 1'b0 || s0_bresp !== 2'b00) begin
                bad++;
                $display("[TB] FAIL early_b c=%0d bready=%b s0bv=%b s1bv=%b bresp=%b required 0/0/0/00",
                         c, m_bready, s0_bvalid, s1_bvalid, s0_bresp);
            end
            tick();
        end
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        sample();
        total++;
        if (m_bready !== 1'b1 || s0_bvalid !== 1'b1 || s0_bresp !== 2'b01) begin
            bad++;
            $display("[TB] FAIL early_b_wait bready=%b bvalid=%b bresp=%b required 1/1/01",
                     m_bready, s0_bvalid, s0_bresp);
        end
        tick();
        clear_inputs();
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL early_b_idle busy=%b required 0", busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clear_inputs();
        do_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_backpressure();
        test_reset_mid();
        test_early_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
